// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// The command struct is sized for the widest supported RAM (32-bit address
// and data); the top zero-extends into it and slices back down.
package ram_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int MAX_NUM_REQ = 4;
  localparam int IDX_W       = 2;
  localparam int CMD_AW      = 32;
  localparam int CMD_DW      = 32;

  typedef struct packed {
    logic              we;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
    logic [IDX_W-1:0]  idx;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant to the first requester found when
// searching from one past the pointer and wrapping to index 0.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic found;

  // Two passes: indices above the pointer first, then the wrapped range.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (i > int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (i <= int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Single-port RAM arbiter: round-robin among NUM_REQ requesters, one access
// per cycle. Pipeline: command stage drives the RAM, read stage waits for the
// registered RAM output, response stage presents rsp_valid/rsp_rdata.
// DATA_WIDTH and ADDR_WIDTH are limited to 32 by the shared command struct.
module ram_sp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]         ram_data_in,
  output logic                          ram_write_en,
  output logic                          ram_chip_sel,
  input  logic [DATA_WIDTH-1:0]         ram_data_out
);

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  cmd_vld_q, cmd_vld_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  unused_cmd_bits;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // Acceptance is combinational; nothing is offered while disabled or in reset.
  always_comb begin
    req_ready = (arb_en && rst_n) ? grant : '0;
  end

  // Next-state for pointer and the three pipeline stages.
  always_comb begin
    cmd_vld_d = |req_ready;
    cmd_d     = cmd_q;
    ptr_d     = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        cmd_d.we    = req_we[i];
        cmd_d.addr  = CMD_AW'(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        cmd_d.wdata = CMD_DW'(req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
        cmd_d.idx   = IDX_W'(i);
        ptr_d       = IDX_W'(i);
      end
    end
    // Only reads travel past the command stage; writes finish at the RAM.
    rd_vld_d = cmd_vld_q && !cmd_q.we;
    rd_idx_d = cmd_q.idx;
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = rd_vld_q && (rd_idx_q == IDX_W'(i));
    end
    rsp_rdata_d = rd_vld_q ? ram_data_out : rsp_rdata_q;
  end

  // State registers; reset flushes everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      cmd_vld_q   <= 1'b0;
      cmd_q       <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_q       <= cmd_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_chip_sel = cmd_vld_q;
  assign ram_write_en = cmd_vld_q && cmd_q.we;
  assign ram_address  = cmd_q.addr[ADDR_WIDTH-1:0];
  assign ram_data_in  = cmd_q.wdata[DATA_WIDTH-1:0];
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;

  // Upper struct bits beyond the configured widths are constant zero.
  assign unused_cmd_bits = ^{cmd_q.addr, cmd_q.wdata};

endmodule

// File: doc/ram_sp_arbiter.md
RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 SHALL have parameter NUM_REQ, default 2, number of requesters, legal range 2..4.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port arb_en  input  1  when high, new grants are allowed.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester request.
REQ-008 SHALL have port req_we  input  NUM_REQ  per-requester write flag (1 = write, 0 = read).
REQ-009 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-010 SHALL have port req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, requester i at slice i.
REQ-011 SHALL have port req_ready  output  NUM_REQ  one-hot acceptance, combinational.
REQ-012 SHALL have port rsp_valid  output  NUM_REQ  one-hot read-data-valid.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data shared by all requesters.
REQ-014 SHALL have port ram_address  output  ADDR_WIDTH  to RAM address.
REQ-015 SHALL have port ram_data_in  output  DATA_WIDTH  to RAM write data.
REQ-016 SHALL have port ram_write_en  output  1  to RAM write enable.
REQ-017 SHALL have port ram_chip_sel  output  1  to RAM chip select.
REQ-018 SHALL have port ram_data_out  input  DATA_WIDTH  from RAM registered read data.

Function
REQ-019 SHALL accept a request when req_valid[i] and req_ready[i] are both high at a rising edge, and SHALL raise at most one req_ready bit per cycle.
REQ-020 SHALL select the winner round-robin: search starts one past the last-granted index and wraps from NUM_REQ-1 to 0.
REQ-021 SHALL hold all req_ready low while arb_en is low; accesses already accepted SHALL still complete.
REQ-022 SHALL register each accepted request (addr, wdata, we, index) into a command stage that drives the RAM ports in the following cycle, with ram_chip_sel=1.
REQ-023 SHALL drive ram_chip_sel=0 and ram_write_en=0 in every cycle in which the command stage is empty.
REQ-024 SHALL give read latency 2: for a read accepted at edge N, rsp_valid[i]=1 during the cycle after edge N+2, with rsp_rdata=ram_data_out.
REQ-025 SHALL produce no rsp_valid for writes; a write completes when the RAM samples it, at edge N+1.
REQ-026 SHALL sustain one access per cycle (back-to-back grants, mixed read/write) with no bubbles.
REQ-027 SHALL guarantee ordering: a read issued after a write to the same address, from any requester, returns the written data.
REQ-028 SHALL update the round-robin pointer only on acceptance; an idle cycle leaves it unchanged.
REQ-029 SHALL grant a lone requester every cycle it is valid, whatever the pointer value.

Reset
REQ-030 SHALL, while rst_n is low, clear the command and response stages, set the pointer so that requester 0 has top priority, and drive req_ready=0, rsp_valid=0, ram_chip_sel=0, ram_write_en=0, ram_address=0, ram_data_in=0, rsp_rdata=0.
REQ-031 SHALL discard in-flight accesses when reset is asserted mid-operation; no rsp_valid is produced for them after reset is released.

Structure
REQ-032 SHALL use a shared package ram_arb_pkg holding the default NUM_REQ, the index-width constant, and a command struct typedef {we, addr, wdata, idx}.
REQ-033 SHALL isolate the round-robin picker in one sub-module, rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-034 SHALL cover: write 0xA5 to address 0x10 by req0, then a read of 0x10 by req1 -> rsp_valid[1] two edges after acceptance, rsp_rdata=0xA5.
REQ-035 SHALL cover: req0 and req1 held valid for 6 cycles -> grants alternate 0,1,0,1,0,1; ram_chip_sel high in 6 consecutive cycles.
REQ-036 SHALL cover: arb_en dropped in the cycle after a read is accepted -> no further req_ready, and the pending rsp_valid still arrives.
REQ-037 SHALL cover: rst_n pulsed low one cycle after a read is accepted -> no rsp_valid, all outputs 0, and the next simultaneous request grants req0.
REQ-038 SHALL cover: NUM_REQ=4 with only req3 valid for 4 cycles -> req_ready[3]=1 in every cycle and reads return the correct data in order.
